nvdla_mcif_write_ig_cmd_arb: RTL and testbench

NVDLA_MCIF_WRITE_IG_CMD_ARB -- requirements
Module: nvdla_mcif_write_ig_cmd_arb

---
 rtl/nvdla_mcif_write_ig_cmd_arb_if.sv | 27 ++
 rtl/nvdla_mcif_write_ig_cmd_arb.sv | 126 ++++++++++++
 tb/tb_nvdla_mcif_write_ig_cmd_arb.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nvdla_mcif_write_ig_cmd_arb_if.sv
// Handshake bundle between the command sources, the weight registers and the
// downstream splitter for the MCIF write ingress command arbiter.
interface nvdla_mcif_write_ig_cmd_arb_if #(
  parameter int PD_W    = 77,
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0]      src_cmd_vld;
  logic [NUM_SRC*PD_W-1:0] src_cmd_pd;
  logic [NUM_SRC-1:0]      src_cmd_rdy;
  logic [NUM_SRC*8-1:0]    reg2arb_wt;
  logic                    arb2spt_cmd_vld;
  logic [PD_W-1:0]         arb2spt_cmd_pd;
  logic [1:0]              arb2spt_cmd_id;
  logic                    arb2spt_cmd_rdy;

  // Environment side: sources, weight registers and the downstream consumer.
  modport master (
    output src_cmd_vld, src_cmd_pd, reg2arb_wt, arb2spt_cmd_rdy,
    input  src_cmd_rdy, arb2spt_cmd_vld, arb2spt_cmd_pd, arb2spt_cmd_id
  );

  // Arbiter side.
  modport slave (
    input  src_cmd_vld, src_cmd_pd, reg2arb_wt, arb2spt_cmd_rdy,
    output src_cmd_rdy, arb2spt_cmd_vld, arb2spt_cmd_pd, arb2spt_cmd_id
  );
endinterface

// File: rtl/nvdla_mcif_write_ig_cmd_arb.sv
// Four-source write command arbiter with a one-entry registered output stage.
// Define NVDLA_MCIF_WRITE_IG_ARB_WT_EN for weighted burst-then-rotate; default is plain round-robin.
module nvdla_mcif_write_ig_cmd_arb #(
  parameter int PD_W    = 77,
  parameter int NUM_SRC = 4
) (
  input logic                          nvdla_core_clk,
  input logic                          nvdla_core_rst,
  nvdla_mcif_write_ig_cmd_arb_if.slave arb
);

  logic               outFree;
  logic               xfer;
  logic               gntAny;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] gnt;
  logic [1:0]         gntIdx;
  logic [1:0]         searchIdx;
  logic [1:0]         ptr_q, ptr_d;
  logic               vld_q, vld_d;
  logic [PD_W-1:0]    pd_q, pd_d;
  logic [1:0]         id_q, id_d;

  // The output slot can take a new command when empty or being drained this cycle.
  assign outFree = !vld_q || arb.arb2spt_cmd_rdy;

`ifdef NVDLA_MCIF_WRITE_IG_ARB_WT_EN
  logic [NUM_SRC-1:0][7:0] credit_q, credit_d, effCredit;
  logic [NUM_SRC-1:0]      hasCredit;
  logic                    needReload;
  logic [7:0]              grantedLeft;

  // When every valid source is out of credit, arbitrate on freshly loaded weights this same cycle.
  always_comb begin
    hasCredit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hasCredit[i] = arb.src_cmd_vld[i] && (credit_q[i] != 8'd0);
    end
    needReload = (|arb.src_cmd_vld) && !(|hasCredit);
    effCredit  = needReload ? arb.reg2arb_wt : credit_q;
    eligible   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = arb.src_cmd_vld[i] && (effCredit[i] != 8'd0);
    end
  end

  always_comb begin
    credit_d    = needReload ? effCredit : credit_q;
    ptr_d       = ptr_q;
    grantedLeft = effCredit[gntIdx] - 8'd1;
    if (xfer) begin
      credit_d[gntIdx] = grantedLeft;
      ptr_d            = (grantedLeft != 8'd0) ? gntIdx : gntIdx + 2'd1;
    end
  end
`else
  logic unused_wt;

  assign unused_wt = ^arb.reg2arb_wt;
  assign eligible  = arb.src_cmd_vld;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = gntIdx + 2'd1;
    end
  end
`endif

  // Circular first-eligible search starting at the pointer.
  always_comb begin
    gnt       = '0;
    gntIdx    = ptr_q;
    gntAny    = 1'b0;
    searchIdx = ptr_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      searchIdx = ptr_q + 2'(k);
      if (!gntAny && eligible[searchIdx]) begin
        gntAny = 1'b1;
        gntIdx = searchIdx;
      end
    end
    gnt[gntIdx] = gntAny;
  end

  assign xfer            = gntAny && outFree && !nvdla_core_rst;
  assign arb.src_cmd_rdy = (outFree && !nvdla_core_rst) ? gnt : '0;

  always_comb begin
    vld_d = vld_q;
    pd_d  = pd_q;
    id_d  = id_q;
    if (xfer) begin
      vld_d = 1'b1;
      pd_d  = arb.src_cmd_pd[int'(gntIdx)*PD_W +: PD_W];
      id_d  = gntIdx;
    end else if (arb.arb2spt_cmd_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      ptr_q    <= 2'd0;
      vld_q    <= 1'b0;
      pd_q     <= '0;
      id_q     <= 2'd0;
`ifdef NVDLA_MCIF_WRITE_IG_ARB_WT_EN
      credit_q <= '0;
`endif
    end else begin
      ptr_q    <= ptr_d;
      vld_q    <= vld_d;
      pd_q     <= pd_d;
      id_q     <= id_d;
`ifdef NVDLA_MCIF_WRITE_IG_ARB_WT_EN
      credit_q <= credit_d;
`endif
    end
  end

  assign arb.arb2spt_cmd_vld = vld_q;
  assign arb.arb2spt_cmd_pd  = pd_q;
  assign arb.arb2spt_cmd_id  = id_q;

endmodule

// File: tb/tb_nvdla_mcif_write_ig_cmd_arb.sv
// Scoreboard bench for nvdla_mcif_write_ig_cmd_arb: expected ids are queued as
// stimulus starts and each payload encodes {source, per-source sequence number}.
module tb_nvdla_mcif_write_ig_cmd_arb;
  localparam int PD_W    = 77;
  localparam int NUM_SRC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nvdla_mcif_write_ig_cmd_arb_if #(.PD_W(PD_W), .NUM_SRC(NUM_SRC)) bus ();

  nvdla_mcif_write_ig_cmd_arb #(.PD_W(PD_W), .NUM_SRC(NUM_SRC)) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .arb           (bus)
  );

  int         total = 0;
  int         bad = 0;
  int         cnt[NUM_SRC];
  int         expectCnt[NUM_SRC];
  int         acceptedTotal = 0;
  int         outCount = 0;
  logic [1:0] expQ[$];

  function automatic logic [PD_W-1:0] pdFor(input int s, input int n);
    logic [1:0]  sid;
    logic [31:0] seq;
    sid = s[1:0];
    seq = n;
    return {sid, 43'd0, seq};
  endfunction

  task automatic setPd();
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.src_cmd_pd[i*PD_W +: PD_W] = pdFor(i, cnt[i]);
    end
  endtask

  // One clock: scoreboard the output at the falling edge, then advance each
  // accepted source to its next command just after the rising edge.
  task automatic tick();
    logic [NUM_SRC-1:0] accNow;
    logic [1:0]         e;
    @(negedge clk);
    accNow = '0;
    if (!rst) begin
      accNow = bus.src_cmd_vld & bus.src_cmd_rdy;
      if (bus.arb2spt_cmd_vld && bus.arb2spt_cmd_rdy) begin
        total++;
        outCount++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_output: got id=%0d pd=%0h, wanted no output",
                   bus.arb2spt_cmd_id, bus.arb2spt_cmd_pd);
        end else begin
          e = expQ.pop_front();
          if (bus.arb2spt_cmd_id !== e || bus.arb2spt_cmd_pd !== pdFor(int'(e), expectCnt[e])) begin
            bad++;
            $display("[TB] FAIL scoreboard: got id=%0d pd=%0h, wanted id=%0d pd=%0h",
                     bus.arb2spt_cmd_id, bus.arb2spt_cmd_pd, e, pdFor(int'(e), expectCnt[e]));
          end
          expectCnt[e]++;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (accNow[i]) begin
        cnt[i]++;
        acceptedTotal++;
      end
    end
    setPd();
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    expQ.delete();
    for (int i = 0; i < NUM_SRC; i++) expectCnt[i] = cnt[i];
    rst = 1'b0;
    #1;
  endtask

  // Keeps sources valid until k commands are accepted, then drains the output.
  task automatic runStream(input int k, input int budget, output int ticks, output bit ok);
    int start;
    int n;
    start = acceptedTotal;
    ticks = 0;
    while ((acceptedTotal - start) < k && ticks < budget) begin
      tick();
      ticks++;
    end
    ok = ((acceptedTotal - start) == k);
    bus.src_cmd_vld = '0;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (expQ.size() != 0) ok = 1'b0;
  endtask

  task automatic test_reset();
    bus.src_cmd_vld     = 4'b1111;
    bus.reg2arb_wt      = {8'd1, 8'd1, 8'd1, 8'd1};
    bus.arb2spt_cmd_rdy = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (bus.arb2spt_cmd_vld !== 1'b0) begin bad++; $display("[TB] FAIL reset_vld: got %0b, wanted 0", bus.arb2spt_cmd_vld); end
    total++;
    if (bus.arb2spt_cmd_id !== 2'd0) begin bad++; $display("[TB] FAIL reset_id: got %0d, wanted 0", bus.arb2spt_cmd_id); end
    total++;
    if (bus.arb2spt_cmd_pd !== '0) begin bad++; $display("[TB] FAIL reset_pd: got %0h, wanted 0", bus.arb2spt_cmd_pd); end
    total++;
    if (bus.src_cmd_rdy !== 4'b0000) begin bad++; $display("[TB] FAIL reset_rdy: got %b, wanted 0000", bus.src_cmd_rdy); end
  endtask

  task automatic test_round_robin();
    int ticks;
    bit ok;
    bus.src_cmd_vld     = 4'b1111;
    bus.reg2arb_wt      = {8'd1, 8'd1, 8'd1, 8'd1};
    bus.arb2spt_cmd_rdy = 1'b1;
    doReset();
    total++;
    if (bus.src_cmd_rdy !== 4'b0001) begin bad++; $display("[TB] FAIL rr_first_rdy: got %b, wanted 0001", bus.src_cmd_rdy); end
    total++;
    if (bus.arb2spt_cmd_vld !== 1'b0) begin bad++; $display("[TB] FAIL rr_vld_before: got %0b, wanted 0", bus.arb2spt_cmd_vld); end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_SRC; i++) expQ.push_back(2'(i));
    end
    tick();
    total++;
    if (bus.arb2spt_cmd_vld !== 1'b1 || bus.arb2spt_cmd_id !== 2'd0) begin
      bad++;
      $display("[TB] FAIL rr_first_out: got vld=%0b id=%0d, wanted vld=1 id=0", bus.arb2spt_cmd_vld, bus.arb2spt_cmd_id);
    end
    runStream(7, 50, ticks, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL rr_stream: got incomplete, wanted all 8 delivered"); end
    total++;
    if (ticks !== 7) begin bad++; $display("[TB] FAIL rr_throughput: got %0d cycles, wanted 7", ticks); end
    total++;
    if (bus.arb2spt_cmd_vld !== 1'b0) begin bad++; $display("[TB] FAIL rr_drained: got vld=%0b, wanted 0", bus.arb2spt_cmd_vld); end
  endtask

  task automatic test_stall();
    int ticks;
    int startOut;
    int startAcc;
    int n;
    bit ok;
    logic [1:0] held;
    bus.src_cmd_vld     = 4'b1111;
    bus.reg2arb_wt      = {8'd1, 8'd1, 8'd1, 8'd1};
    bus.arb2spt_cmd_rdy = 1'b1;
    doReset();
    startOut = outCount;
    startAcc = acceptedTotal;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_SRC; i++) expQ.push_back(2'(i));
    end
    n = 0;
    while ((outCount - startOut) < 2 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if ((outCount - startOut) !== 2) begin bad++; $display("[TB] FAIL stall_setup: got %0d outputs, wanted 2", outCount - startOut); end
    bus.arb2spt_cmd_rdy = 1'b0;
    held = expQ[0];
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (bus.arb2spt_cmd_vld !== 1'b1 || bus.arb2spt_cmd_id !== held ||
          bus.arb2spt_cmd_pd !== pdFor(int'(held), expectCnt[held])) begin
        bad++;
        $display("[TB] FAIL stall_hold: got vld=%0b id=%0d pd=%0h, wanted vld=1 id=%0d pd=%0h",
                 bus.arb2spt_cmd_vld, bus.arb2spt_cmd_id, bus.arb2spt_cmd_pd, held, pdFor(int'(held), expectCnt[held]));
      end
      total++;
      if (bus.src_cmd_rdy !== 4'b0000) begin bad++; $display("[TB] FAIL stall_rdy: got %b, wanted 0000", bus.src_cmd_rdy); end
      tick();
    end
    bus.arb2spt_cmd_rdy = 1'b1;
    runStream(8 - (acceptedTotal - startAcc), 50, ticks, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL stall_resume: got incomplete, wanted all delivered"); end
    total++;
    if ((outCount - startOut) !== 8) begin bad++; $display("[TB] FAIL stall_count: got %0d outputs, wanted 8", outCount - startOut); end
    total++;
    if (bus.arb2spt_cmd_vld !== 1'b0) begin bad++; $display("[TB] FAIL stall_drained: got vld=%0b, wanted 0", bus.arb2spt_cmd_vld); end
  endtask

  task automatic test_reset_mid();
    int ticks;
    bit ok;
    bus.src_cmd_vld     = 4'b1111;
    bus.reg2arb_wt      = {8'd1, 8'd1, 8'd1, 8'd1};
    bus.arb2spt_cmd_rdy = 1'b1;
    doReset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_SRC; i++) expQ.push_back(2'(i));
    end
    tick();
    tick();
    tick();
    total++;
    if (bus.arb2spt_cmd_vld !== 1'b1 || bus.arb2spt_cmd_id !== 2'd2) begin
      bad++;
      $display("[TB] FAIL midrst_pre: got vld=%0b id=%0d, wanted vld=1 id=2", bus.arb2spt_cmd_vld, bus.arb2spt_cmd_id);
    end
    rst = 1'b1;
    tick();
    total++;
    if (bus.arb2spt_cmd_vld !== 1'b0) begin bad++; $display("[TB] FAIL midrst_vld: got %0b, wanted 0", bus.arb2spt_cmd_vld); end
    total++;
    if (bus.arb2spt_cmd_id !== 2'd0) begin bad++; $display("[TB] FAIL midrst_id: got %0d, wanted 0", bus.arb2spt_cmd_id); end
    total++;
    if (bus.src_cmd_rdy !== 4'b0000) begin bad++; $display("[TB] FAIL midrst_rdy: got %b, wanted 0000", bus.src_cmd_rdy); end
    expQ.delete();
    for (int i = 0; i < NUM_SRC; i++) expectCnt[i] = cnt[i];
    rst = 1'b0;
    #1;
    for (int i = 0; i < NUM_SRC; i++) expQ.push_back(2'(i));
    tick();
    total++;
    if (bus.arb2spt_cmd_vld !== 1'b1 || bus.arb2spt_cmd_id !== 2'd0) begin
      bad++;
      $display("[TB] FAIL midrst_restart: got vld=%0b id=%0d, wanted vld=1 id=0", bus.arb2spt_cmd_vld, bus.arb2spt_cmd_id);
    end
    runStream(3, 50, ticks, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL midrst_stream: got incomplete, wanted all delivered"); end
  endtask

`ifdef NVDLA_MCIF_WRITE_IG_ARB_WT_EN
  task automatic test_weighted();
    int ticks;
    int start;
    bit ok;
    bit seen3;
    logic [1:0] pattern [6];
    pattern = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2};
    bus.src_cmd_vld     = 4'b1111;
    bus.reg2arb_wt      = {8'd0, 8'd2, 8'd1, 8'd3};
    bus.arb2spt_cmd_rdy = 1'b1;
    doReset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) expQ.push_back(pattern[i]);
    end
    start = acceptedTotal;
    seen3 = 1'b0;
    ticks = 0;
    while ((acceptedTotal - start) < 12 && ticks < 60) begin
      if (bus.src_cmd_rdy[3]) seen3 = 1'b1;
      tick();
      ticks++;
    end
    total++;
    if (ticks !== 12) begin bad++; $display("[TB] FAIL wt_throughput: got %0d cycles, wanted 12", ticks); end
    runStream(0, 50, ticks, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL wt_stream: got incomplete, wanted all delivered"); end
    total++;
    if (seen3 !== 1'b0) begin bad++; $display("[TB] FAIL wt_src3_rdy: got asserted, wanted never"); end
  endtask

  task automatic test_single_src();
    int ticks;
    bit ok;
    bus.src_cmd_vld     = 4'b0010;
    bus.reg2arb_wt      = {8'd2, 8'd2, 8'd2, 8'd2};
    bus.arb2spt_cmd_rdy = 1'b1;
    doReset();
    for (int i = 0; i < 6; i++) expQ.push_back(2'd1);
    runStream(6, 50, ticks, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL single_stream: got incomplete, wanted all delivered"); end
    total++;
    if (ticks !== 6) begin bad++; $display("[TB] FAIL single_no_bubble: got %0d cycles, wanted 6", ticks); end
  endtask

  task automatic test_all_zero();
    bit sawRdy;
    bit sawVld;
    bus.src_cmd_vld     = 4'b1111;
    bus.reg2arb_wt      = '0;
    bus.arb2spt_cmd_rdy = 1'b1;
    doReset();
    sawRdy = 1'b0;
    sawVld = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.src_cmd_rdy !== 4'b0000) sawRdy = 1'b1;
      tick();
      if (bus.arb2spt_cmd_vld !== 1'b0) sawVld = 1'b1;
    end
    total++;
    if (sawRdy) begin bad++; $display("[TB] FAIL zero_wt_rdy: got asserted, wanted 0000"); end
    total++;
    if (sawVld) begin bad++; $display("[TB] FAIL zero_wt_vld: got asserted, wanted 0"); end
    bus.src_cmd_vld = '0;
  endtask
`else
  task automatic test_no_weights();
    int ticks;
    bit ok;
    bus.src_cmd_vld     = 4'b0101;
    bus.reg2arb_wt      = '0;
    bus.arb2spt_cmd_rdy = 1'b1;
    doReset();
    expQ.push_back(2'd0);
    expQ.push_back(2'd2);
    expQ.push_back(2'd0);
    expQ.push_back(2'd2);
    runStream(4, 50, ticks, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL rr_zero_wt_stream: got incomplete, wanted all delivered"); end
    total++;
    if (ticks !== 4) begin bad++; $display("[TB] FAIL rr_zero_wt_rate: got %0d cycles, wanted 4", ticks); end
    total++;
    if (bus.arb2spt_cmd_vld !== 1'b0) begin bad++; $display("[TB] FAIL rr_zero_wt_drained: got vld=%0b, wanted 0", bus.arb2spt_cmd_vld); end
  endtask
`endif

  initial begin
    for (int i = 0; i < NUM_SRC; i++) begin
      cnt[i]       = 0;
      expectCnt[i] = 0;
    end
    bus.src_cmd_vld     = '0;
    bus.reg2arb_wt      = '0;
    bus.arb2spt_cmd_rdy = 1'b0;
    setPd();
    $display("[TB] starting");
    test_reset();
    test_round_robin();
    test_stall();
    test_reset_mid();
`ifdef NVDLA_MCIF_WRITE_IG_ARB_WT_EN
    test_weighted();
    test_single_src();
    test_all_zero();
`else
    test_no_weights();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
